// File: rtl/uart_tx.sv
// UART transmitter: one bit per CLK, frame = start(0), data LSB-first, optional parity, stop(1).
// Optional feature: define UART_TX_STOP2_EN for two stop bits (can_send pulses in the second one).

module uart_tx_checker (
    input logic clk,
    input logic reset,
    input logic data_valid,
    input logic busy,
    input logic tx_out,
    input logic can_send
);

    // An idle transmitter must hold the line high
    a_idle_line_high: assert property (@(posedge clk) disable iff (reset)
        !busy |-> tx_out);

    // can_send only appears during a stop bit of an active frame
    a_can_send_in_stop: assert property (@(posedge clk) disable iff (reset)
        can_send |-> (busy && tx_out));

    // can_send is a single-cycle pulse
    a_can_send_pulse: assert property (@(posedge clk) disable iff (reset)
        can_send |=> !can_send);

    // A request seen while idle produces a start bit on the next cycle
    a_accept_start: assert property (@(posedge clk) disable iff (reset)
        (!busy && data_valid) |=> (busy && !tx_out));

endmodule

module uart_tx #(
    parameter int width = 8
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Parity_type,
    input  logic             Parity_EN,
    input  logic             Data_valid,
    input  logic [width-1:0] Data,
    output logic             Busy,
    output logic             Tx_out,
    output logic             can_send
);

    localparam int CNT_W = (width > 1) ? $clog2(width) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(width - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef UART_TX_STOP2_EN
    localparam logic STOP_LAST = 1'b1;
`else
    localparam logic STOP_LAST = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Even parity is the XOR of the data; odd parity is its complement
    function automatic logic parity_bit(input logic [width-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    state_t           state_r;
    state_t           next_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             stop_cnt_r;
    logic             stop_cnt_next_s;
    logic [width-1:0] data_r;
    logic [width-1:0] data_next_s;
    logic             par_en_r;
    logic             par_en_next_s;
    logic             par_type_r;
    logic             par_type_next_s;
    logic             tx_out_r;
    logic             tx_next_s;
    logic             busy_r;
    logic             busy_next_s;
    logic             can_send_r;
    logic             can_send_next_s;

    // Next-state, counter and frame-latch logic
    always_comb begin
        next_state_s    = state_r;
        cnt_next_s      = cnt_r;
        stop_cnt_next_s = stop_cnt_r;
        data_next_s     = data_r;
        par_en_next_s   = par_en_r;
        par_type_next_s = par_type_r;
        case (state_r)
            IDLE: begin
                if (Data_valid) begin
                    next_state_s    = START;
                    data_next_s     = Data;
                    par_en_next_s   = Parity_EN;
                    par_type_next_s = Parity_type;
                    cnt_next_s      = '0;
                    stop_cnt_next_s = 1'b0;
                end else begin
                    next_state_s = IDLE;
                end
            end
            START: begin
                next_state_s = DATA;
                cnt_next_s   = '0;
            end
            DATA: begin
                if (cnt_r == LAST_BIT) begin
                    cnt_next_s      = '0;
                    stop_cnt_next_s = 1'b0;
                    if (par_en_r) begin
                        next_state_s = PARITY;
                    end else begin
                        next_state_s = STOP;
                    end
                end else begin
                    cnt_next_s = cnt_r + CNT_ONE;
                end
            end
            PARITY: begin
                next_state_s    = STOP;
                stop_cnt_next_s = 1'b0;
            end
            STOP: begin
                if (stop_cnt_r == STOP_LAST) begin
                    next_state_s    = IDLE;
                    stop_cnt_next_s = 1'b0;
                end else begin
                    stop_cnt_next_s = stop_cnt_r + 1'b1;
                end
            end
            default: begin
                next_state_s    = IDLE;
                cnt_next_s      = '0;
                stop_cnt_next_s = 1'b0;
            end
        endcase
    end

    // Outputs are derived from the state being entered so they register in the same edge
    always_comb begin
        tx_next_s       = 1'b1;
        busy_next_s     = 1'b1;
        can_send_next_s = 1'b0;
        case (next_state_s)
            IDLE: begin
                busy_next_s = 1'b0;
            end
            START: begin
                tx_next_s = 1'b0;
            end
            DATA: begin
                tx_next_s = data_next_s[cnt_next_s];
            end
            PARITY: begin
                tx_next_s = parity_bit(data_next_s, par_type_next_s);
            end
            STOP: begin
                can_send_next_s = (stop_cnt_next_s == STOP_LAST);
            end
            default: begin
                tx_next_s   = 1'b1;
                busy_next_s = 1'b0;
            end
        endcase
    end

    // State, frame latches and registered outputs; reset aborts any frame in flight
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            stop_cnt_r <= 1'b0;
            data_r     <= '0;
            par_en_r   <= 1'b0;
            par_type_r <= 1'b0;
            tx_out_r   <= 1'b1;
            busy_r     <= 1'b0;
            can_send_r <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            cnt_r      <= cnt_next_s;
            stop_cnt_r <= stop_cnt_next_s;
            data_r     <= data_next_s;
            par_en_r   <= par_en_next_s;
            par_type_r <= par_type_next_s;
            tx_out_r   <= tx_next_s;
            busy_r     <= busy_next_s;
            can_send_r <= can_send_next_s;
        end
    end

    assign Tx_out   = tx_out_r;
    assign Busy     = busy_r;
    assign can_send = can_send_r;

    uart_tx_checker u_checker (
        .clk        (CLK),
        .reset      (Reset),
        .data_valid (Data_valid),
        .busy       (busy_r),
        .tx_out     (tx_out_r),
        .can_send   (can_send_r)
    );

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a per-cycle scoreboard of {Tx_out, Busy, can_send}.
// Honours UART_TX_STOP2_EN when the design is built with two stop bits.

module tb_uart_tx;

    localparam int width = 8;
`ifdef UART_TX_STOP2_EN
    localparam int STOP_BITS = 2;
`else
    localparam int STOP_BITS = 1;
`endif

    logic             CLK = 1'b0;
    logic             Reset = 1'b1;
    logic             Parity_type = 1'b0;
    logic             Parity_EN = 1'b0;
    logic             Data_valid = 1'b0;
    logic [width-1:0] Data = '0;
    logic             Busy;
    logic             Tx_out;
    logic             can_send;

    int total = 0;
    int bad = 0;
    logic [2:0] exp_q[$];
    logic [2:0] exp_v;
    logic [2:0] obs_v;

    uart_tx #(.width(width)) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .Parity_type (Parity_type),
        .Parity_EN   (Parity_EN),
        .Data_valid  (Data_valid),
        .Data        (Data),
        .Busy        (Busy),
        .Tx_out      (Tx_out),
        .can_send    (can_send)
    );

    always #5 CLK = ~CLK;

    function automatic int frame_len(input logic pen);
        return width + 1 + (pen ? 1 : 0) + STOP_BITS;
    endfunction

    // Expected {tx, busy, can_send} per cycle of one frame
    function automatic void push_frame(input logic [width-1:0] d, input logic pen, input logic ptype);
        int ones = 0;
        exp_q.push_back(3'b010);
        for (int i = 0; i < width; i++) begin
            exp_q.push_back({d[i], 1'b1, 1'b0});
            if (d[i]) ones++;
        end
        if (pen) exp_q.push_back({(ptype ? ((ones % 2) == 0) : ((ones % 2) == 1)), 1'b1, 1'b0});
        for (int s = 1; s <= STOP_BITS; s++) exp_q.push_back({1'b1, 1'b1, (s == STOP_BITS)});
    endfunction

    function automatic void push_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(3'b100);
    endfunction

    task automatic test_reset();
        Reset = 1'b1;
        Data_valid = 1'b0;
        push_idle(2);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge CLK);
            exp_v = exp_q.pop_front();
            obs_v = {Tx_out, Busy, can_send};
            total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("FAIL reset_hold cycle %0d: tx/busy/cs got %b expected %b", i, obs_v, exp_v);
            end
        end
        Reset = 1'b0;
        push_idle(20);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge CLK);
            exp_v = exp_q.pop_front();
            obs_v = {Tx_out, Busy, can_send};
            total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("FAIL reset_idle cycle %0d: tx/busy/cs got %b expected %b", i, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_parity_even();
        Data = 8'h55;
        Parity_EN = 1'b1;
        Parity_type = 1'b0;
        Data_valid = 1'b1;
        push_frame(8'h55, 1'b1, 1'b0);
        push_idle(2);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge CLK);
            exp_v = exp_q.pop_front();
            obs_v = {Tx_out, Busy, can_send};
            total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("FAIL even_0x55 cycle %0d: tx/busy/cs got %b expected %b", i, obs_v, exp_v);
            end
            Data_valid = 1'b0;
        end
    endtask

    task automatic test_ignore_midframe();
        int len = frame_len(1'b1);
        Data = 8'h55;
        Parity_EN = 1'b1;
        Parity_type = 1'b0;
        Data_valid = 1'b1;
        push_frame(8'h55, 1'b1, 1'b0);
        push_idle(3);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge CLK);
            exp_v = exp_q.pop_front();
            obs_v = {Tx_out, Busy, can_send};
            total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("FAIL busy_ignore cycle %0d: tx/busy/cs got %b expected %b", i, obs_v, exp_v);
            end
            if (i == 3) begin
                Data = 8'hAA;
                Parity_type = 1'b1;
                Parity_EN = 1'b0;
                Data_valid = 1'b1;
            end else if (i == len - 1) begin
                Data_valid = 1'b1;
            end else begin
                Data_valid = 1'b0;
            end
        end
        Data = 8'hAA;
        Parity_EN = 1'b1;
        Parity_type = 1'b1;
        Data_valid = 1'b1;
        push_frame(8'hAA, 1'b1, 1'b1);
        push_idle(2);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge CLK);
            exp_v = exp_q.pop_front();
            obs_v = {Tx_out, Busy, can_send};
            total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("FAIL odd_0xAA cycle %0d: tx/busy/cs got %b expected %b", i, obs_v, exp_v);
            end
            Data_valid = 1'b0;
        end
    endtask

    task automatic test_no_parity();
        Data = 8'hCA;
        Parity_EN = 1'b0;
        Parity_type = 1'b1;
        Data_valid = 1'b1;
        push_frame(8'hCA, 1'b0, 1'b1);
        push_idle(2);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge CLK);
            exp_v = exp_q.pop_front();
            obs_v = {Tx_out, Busy, can_send};
            total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("FAIL nopar_0xCA cycle %0d: tx/busy/cs got %b expected %b", i, obs_v, exp_v);
            end
            Data_valid = 1'b0;
        end
    endtask

    task automatic test_reset_midframe();
        Data = 8'hF0;
        Parity_EN = 1'b1;
        Parity_type = 1'b1;
        Data_valid = 1'b1;
        push_frame(8'hF0, 1'b1, 1'b1);
        while (exp_q.size() > 5) exp_q.delete(exp_q.size() - 1);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge CLK);
            exp_v = exp_q.pop_front();
            obs_v = {Tx_out, Busy, can_send};
            total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("FAIL pre_abort cycle %0d: tx/busy/cs got %b expected %b", i, obs_v, exp_v);
            end
            Data_valid = 1'b0;
        end
        // Reset during data bit 3, together with a request that reset must override
        Reset = 1'b1;
        Data_valid = 1'b1;
        push_idle(1);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge CLK);
            exp_v = exp_q.pop_front();
            obs_v = {Tx_out, Busy, can_send};
            total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("FAIL abort cycle %0d: tx/busy/cs got %b expected %b", i, obs_v, exp_v);
            end
            Reset = 1'b0;
            Data_valid = 1'b0;
        end
        push_idle(2);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge CLK);
            exp_v = exp_q.pop_front();
            obs_v = {Tx_out, Busy, can_send};
            total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("FAIL post_abort_idle cycle %0d: tx/busy/cs got %b expected %b", i, obs_v, exp_v);
            end
        end
        Data = 8'h96;
        Parity_EN = 1'b1;
        Parity_type = 1'b0;
        Data_valid = 1'b1;
        push_frame(8'h96, 1'b1, 1'b0);
        push_idle(2);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge CLK);
            exp_v = exp_q.pop_front();
            obs_v = {Tx_out, Busy, can_send};
            total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("FAIL fresh_0x96 cycle %0d: tx/busy/cs got %b expected %b", i, obs_v, exp_v);
            end
            Data_valid = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        int len = frame_len(1'b1);
        Data = 8'h3C;
        Parity_EN = 1'b1;
        Parity_type = 1'b0;
        Data_valid = 1'b1;
        for (int a = 1; a <= 30; a += len + 1) begin
            push_frame(8'h3C, 1'b1, 1'b0);
            push_idle(1);
        end
        push_idle(2);
        for (int i = 1; exp_q.size() > 0; i++) begin
            @(negedge CLK);
            exp_v = exp_q.pop_front();
            obs_v = {Tx_out, Busy, can_send};
            total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("FAIL back_to_back cycle %0d: tx/busy/cs got %b expected %b", i, obs_v, exp_v);
            end
            if (i == 30) Data_valid = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion well before", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_parity_even();
        test_ignore_midframe();
        test_no_parity();
        test_reset_midframe();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
